// File: rtl/dds_key_ctrl.sv
// dds_key_ctrl: four independent key controllers (wave, freq, phase, amp)
// that step the DDS control registers once per press.
// Optional build macro: KEY_AUTOREPEAT_EN enables auto-repeat on long holds
// (LONG_CNT hold cycles before the first repeat, then one step every REP_CNT).
module dds_key_ctrl #(
    parameter logic [31:0] FW_STEP  = 32'd85899,
    parameter logic [31:0] FW_MAX   = 32'd858993459,
    parameter logic [11:0] PH_STEP  = 12'd256,
    parameter int unsigned LONG_CNT = 25_000_000,
    parameter int unsigned REP_CNT  = 5_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_wave,
    input  logic        key_freq,
    input  logic        key_phase,
    input  logic        key_amp,
    output logic [1:0]  wave_sel,
    output logic [31:0] freq_word,
    output logic [11:0] phase_word,
    output logic [2:0]  amp_sel,
    output logic [3:0]  key_evt
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
`ifdef KEY_AUTOREPEAT_EN
        HELD,
        REPEAT
`else
        HELD
`endif
    } key_state_t;

    // Bit order matches key_evt: {amp, phase, freq, wave}; keys are active-low.
    logic [3:0] key_lvl;
    assign key_lvl = {key_amp, key_phase, key_freq, key_wave};

    key_state_t state     [4];
    key_state_t state_nxt [4];
    logic [3:0] step;

`ifdef KEY_AUTOREPEAT_EN
    // Counts consecutive low samples in HELD, and cycles since the last step in REPEAT.
    logic [31:0] hold_cnt     [4];
    logic [31:0] hold_cnt_nxt [4];
`endif

    // A zero count would make the repeat comparisons unreachable; reject at elaboration.
    if (LONG_CNT == 0 || REP_CNT == 0) begin : g_bad_repeat_cnt
        $error("dds_key_ctrl: LONG_CNT and REP_CNT must be non-zero");
    end

    // Controller state registers (and hold counters when auto-repeat is built in).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                state[i] <= IDLE;
`ifdef KEY_AUTOREPEAT_EN
                hold_cnt[i] <= '0;
`endif
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                state[i] <= state_nxt[i];
`ifdef KEY_AUTOREPEAT_EN
                hold_cnt[i] <= hold_cnt_nxt[i];
`endif
            end
        end
    end

    // Next-state and step decode per key; a step fires on the edge that changes state.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            state_nxt[i] = state[i];
            step[i]      = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            hold_cnt_nxt[i] = hold_cnt[i];
`endif
            case (state[i])
                IDLE: begin
                    if (key_lvl[i]) state_nxt[i] = ARMED;
                end
                ARMED: begin
                    if (!key_lvl[i]) begin
                        state_nxt[i] = HELD;
                        step[i]      = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                        hold_cnt_nxt[i] = 32'd1;
`endif
                    end
                end
                HELD: begin
                    if (key_lvl[i]) begin
                        state_nxt[i] = ARMED;
`ifdef KEY_AUTOREPEAT_EN
                        hold_cnt_nxt[i] = '0;
                    end else if (hold_cnt[i] == LONG_CNT) begin
                        state_nxt[i]    = REPEAT;
                        step[i]         = 1'b1;
                        hold_cnt_nxt[i] = 32'd1;
                    end else begin
                        hold_cnt_nxt[i] = hold_cnt[i] + 32'd1;
`endif
                    end
                end
`ifdef KEY_AUTOREPEAT_EN
                REPEAT: begin
                    if (key_lvl[i]) begin
                        state_nxt[i]    = ARMED;
                        hold_cnt_nxt[i] = '0;
                    end else if (hold_cnt[i] == REP_CNT) begin
                        step[i]         = 1'b1;
                        hold_cnt_nxt[i] = 32'd1;
                    end else begin
                        hold_cnt_nxt[i] = hold_cnt[i] + 32'd1;
                    end
                end
`endif
                default: state_nxt[i] = IDLE;
            endcase
        end
    end

    // Frequency wrap decision uses a 33-bit sum so overflow cannot mask the limit.
    logic [32:0] freq_sum;
    logic        freq_wrap;
    assign freq_sum  = {1'b0, freq_word} + {1'b0, FW_STEP};
    assign freq_wrap = freq_sum > {1'b0, FW_MAX};

    // Control registers and event pulses, updated on the step edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wave_sel   <= '0;
            freq_word  <= FW_STEP;
            phase_word <= '0;
            amp_sel    <= '0;
            key_evt    <= '0;
        end else begin
            key_evt <= step;
            if (step[0]) wave_sel   <= wave_sel + 2'd1;
            if (step[1]) freq_word  <= freq_wrap ? FW_STEP : freq_sum[31:0];
            if (step[2]) phase_word <= phase_word + PH_STEP;
            if (step[3]) amp_sel    <= amp_sel + 3'd1;
        end
    end

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Scoreboard bench for dds_key_ctrl: a press-counting reference model pushes
// expected register snapshots; a monitor pops one whenever key_evt is non-zero.
module tb_dds_key_ctrl;

    localparam int unsigned LC = 10;
    localparam int unsigned RC = 4;
    localparam logic [31:0] FS = 32'd85899;
    localparam logic [31:0] FM = 32'd858993459;
    localparam logic [11:0] PS = 12'd256;
`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned AMP_AFTER_22 = 4;
`else
    localparam int unsigned AMP_AFTER_22 = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_wave = 1'b1, key_freq = 1'b1, key_phase = 1'b1, key_amp = 1'b1;
    logic [1:0]  wave_sel;
    logic [31:0] freq_word;
    logic [11:0] phase_word;
    logic [2:0]  amp_sel;
    logic [3:0]  key_evt;

    dds_key_ctrl #(
        .FW_STEP(FS), .FW_MAX(FM), .PH_STEP(PS), .LONG_CNT(LC), .REP_CNT(RC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .key_wave(key_wave), .key_freq(key_freq), .key_phase(key_phase), .key_amp(key_amp),
        .wave_sel(wave_sel), .freq_word(freq_word), .phase_word(phase_word),
        .amp_sel(amp_sel), .key_evt(key_evt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  w;
        logic [31:0] f;
        logic [11:0] p;
        logic [2:0]  a;
        logic [3:0]  e;
    } snap_t;

    snap_t exp_q[$];
    int checks = 0;
    int passes = 0;

    // Reference model: a key steps on the first low sample after it has been seen
    // high since reset, and (with auto-repeat) at run lengths LC+1, LC+1+RC, ...
    logic [1:0]  m_w;
    logic [31:0] m_f;
    logic [11:0] m_p;
    logic [2:0]  m_a;
    bit          seen_high [4];
    int unsigned run_len   [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_w = '0; m_f = FS; m_p = '0; m_a = '0;
        for (int i = 0; i < 4; i++) begin
            seen_high[i] = 1'b0;
            run_len[i]   = 0;
        end
    endtask

    function automatic bit fires(input int unsigned run);
        if (run == 1) return 1'b1;
`ifdef KEY_AUTOREPEAT_EN
        if (run > LC && ((run - LC - 1) % RC) == 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Drive one cycle of key levels ({amp,phase,freq,wave}, 0 = pressed) and model the edge.
    task automatic tick(input logic [3:0] k);
        logic [3:0] evt;
        longint unsigned sum;
        {key_amp, key_phase, key_freq, key_wave} = k;
        @(posedge clk);
        evt = '0;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) begin
                seen_high[i] = 1'b1;
                run_len[i]   = 0;
            end else if (seen_high[i]) begin
                run_len[i]++;
                if (fires(run_len[i])) evt[i] = 1'b1;
            end
        end
        if (evt[0]) m_w = m_w + 2'd1;
        if (evt[1]) begin
            sum = longint'(m_f) + longint'(FS);
            m_f = (sum > longint'(FM)) ? FS : m_f + FS;
        end
        if (evt[2]) m_p = m_p + PS;
        if (evt[3]) m_a = m_a + 3'd1;
        if (evt != 4'b0) exp_q.push_back('{w: m_w, f: m_f, p: m_p, a: m_a, e: evt});
        #1;
    endtask

    task automatic press(input int unsigned idx);
        logic [3:0] k;
        k = 4'hF;
        k[idx] = 1'b0;
        tick(k);
        tick(4'hF);
    endtask

    task automatic apply_reset(input logic [3:0] k);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        {key_amp, key_phase, key_freq, key_wave} = k;
        model_reset();
        #1;
        chk("rst_async_wave", wave_sel, 0);
        chk("rst_async_freq", freq_word, FS);
        chk("rst_async_phase", phase_word, 0);
        chk("rst_async_amp", amp_sel, 0);
        chk("rst_async_evt", key_evt, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_freq", freq_word, FS);
        chk("rst_hold_evt", key_evt, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every non-zero key_evt must match the next expected snapshot.
    initial begin
        snap_t s;
        forever begin
            @(negedge clk);
            if (rst_n && key_evt !== 4'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_evt: got %b expected no event", key_evt);
                end else begin
                    s = exp_q.pop_front();
                    chk("sb_evt", key_evt, s.e);
                    chk("sb_wave", wave_sel, s.w);
                    chk("sb_freq", freq_word, s.f);
                    chk("sb_phase", phase_word, s.p);
                    chk("sb_amp", amp_sel, s.a);
                end
            end
        end
    end

    initial begin
        logic [3:0] k;
        int unsigned div;

        apply_reset(4'hF);

        // Single frequency press
        tick(4'hF); tick(4'hF);
        tick(4'b1101);
        chk("freq_first_step", freq_word, 171798);
        chk("freq_first_evt", key_evt, 4'b0010);
        tick(4'hF);
        chk("freq_evt_one_cycle", key_evt, 0);

        // Wave wraps after four presses
        for (int n = 1; n <= 4; n++) begin
            tick(4'b1110);
            chk("wave_press", wave_sel, n % 4);
            tick(4'hF);
        end

        // Amp through 6 -> 7 -> 0 -> ... -> 3
        for (int n = 1; n <= 11; n++) begin
            press(3);
            chk("amp_press", amp_sel, n % 8);
        end

        // Simultaneous wave and freq
        tick(4'b1100);
        chk("dual_evt", key_evt, 4'b0011);
        tick(4'hF);

        // Phase wrap 3840 -> 0
        for (int n = 1; n <= 16; n++) begin
            press(2);
            chk("phase_press", phase_word, (n * 256) % 4096);
        end

        // Randomized key activity with varying toggle rates
        k = 4'hF;
        for (int seg = 0; seg < 20; seg++) begin
            case ($urandom_range(0, 2))
                0: div = 2;
                1: div = 5;
                default: div = 25;
            endcase
            for (int c = 0; c < 200; c++) begin
                for (int b = 0; b < 4; b++)
                    if ($urandom_range(0, div - 1) == 0) k[b] = ~k[b];
                tick(k);
            end
        end
        tick(4'hF);

        // Long hold of the amp key
        apply_reset(4'hF);
        tick(4'hF);
        repeat (22) tick(4'b0111);
        tick(4'hF);
        chk("amp_long_hold", amp_sel, AMP_AFTER_22);

        // Reset mid-hold, key kept low through release
        repeat (15) tick(4'b0111);
        apply_reset(4'b0111);
        repeat (30) tick(4'b0111);
        chk("amp_after_midhold_reset", amp_sel, 0);
        tick(4'hF);
        tick(4'b0111);
        chk("amp_repress", amp_sel, 1);
        tick(4'hF);

        // Phase key held through reset release
        apply_reset(4'b1011);
        repeat (100) tick(4'b1011);
        chk("phase_held_through_reset", phase_word, 0);
        tick(4'hF);
        chk("phase_after_release", phase_word, 0);
        tick(4'b1011);
        chk("phase_second_press", phase_word, 256);
        tick(4'hF);

        // Frequency limit wrap
        apply_reset(4'hF);
        tick(4'hF);
        repeat (9999) press(1);
        chk("freq_at_max", freq_word, 32'd858990000);
        press(1);
        chk("freq_wrap", freq_word, FS);

        // Drain and compare final state against the model
        repeat (3) tick(4'hF);
        chk("queue_empty", exp_q.size(), 0);
        chk("final_wave", wave_sel, m_w);
        chk("final_freq", freq_word, m_f);
        chk("final_phase", phase_word, m_p);
        chk("final_amp", amp_sel, m_a);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
